main_memory_ctrl: RTL and testbench

Shared main-memory controller on the common snoop bus, directly downstream of the per-processor cache wrappers and the bus arbiter. It services cache-line fills (`BusRd`/`BusRdX`) with a programmable access latency and write-backs (`Mem_wr`) with a write latency. It requests the common bus through the arbiter's memory port (`Mem_snoop_req`/`Mem_snoop_gnt`) before driving read data. A fill is dropped when a snooping cache signals `Mem_oprn_abort` because it supplies the data itself.

---
 rtl/main_memory_ctrl.sv | 147 ++++++++++++++
 tb/tb_main_memory_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl.sv
// Shared main-memory controller on the common snoop bus: services line fills after a
// programmable latency, arbitrates for the bus before driving data, and absorbs write-backs.
module main_memory_ctrl #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           MEM_DEPTH_LOG2 = 10,
    parameter int unsigned           RD_LATENCY     = 4,
    parameter int unsigned           WR_LATENCY     = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_PATTERN   = 'h5A5A_5A5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] Address_Com,
    inout  wire  [DATA_WIDTH-1:0] Data_Bus_Com,
    input  logic                  BusRd,
    input  logic                  BusRdX,
    input  logic                  Mem_wr,
    input  logic                  Mem_oprn_abort,
    output logic                  Data_in_Bus,
    output logic                  Mem_write_done,
    output logic                  Mem_snoop_req,
    input  logic                  Mem_snoop_gnt
);

    localparam int unsigned DEPTH   = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned CNT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StReq,
        StDrive,
        StWrWait,
        StWaitRel
    } state_e;

    state_e                  r_state, w_state_d;
    logic [CNT_W-1:0]        r_cnt, w_cnt_d;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_d;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_d;
    logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_d;
    logic                    r_write_done, w_write_done_d;
    logic                    w_mem_we;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]        r_valid;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign w_idx = r_addr[MEM_DEPTH_LOG2+1:2];
    // Never-written entries return a deterministic address-derived word.
    assign w_rd_word = r_valid[w_idx] ? r_mem[w_idx]
                                      : (DATA_WIDTH'(r_addr) ^ FILL_PATTERN);

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_addr_d       = r_addr;
        w_wdata_d      = r_wdata;
        w_rdata_d      = r_rdata;
        w_write_done_d = r_write_done;
        w_mem_we       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (Mem_wr) begin
                    w_addr_d  = Address_Com;
                    w_wdata_d = Data_Bus_Com;
                    w_cnt_d   = CNT_W'(WR_LATENCY - 1);
                    w_state_d = StWrWait;
                end else if (BusRd || BusRdX) begin
                    w_addr_d  = Address_Com;
                    w_cnt_d   = CNT_W'(RD_LATENCY - 1);
                    w_state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (Mem_oprn_abort) begin
                    w_state_d = StWaitRel;
                end else if (r_cnt == '0) begin
                    w_state_d = StReq;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StReq: begin
                if (Mem_oprn_abort) begin
                    w_state_d = StWaitRel;
                end else if (Mem_snoop_gnt) begin
                    w_rdata_d = w_rd_word;
                    w_state_d = StDrive;
                end
            end
            StDrive: w_state_d = StWaitRel;
            StWrWait: begin
                if (r_cnt == '0) begin
                    w_mem_we       = 1'b1;
                    w_write_done_d = 1'b1;
                    w_state_d      = StWaitRel;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StWaitRel: begin
                if (!(BusRd || BusRdX || Mem_wr)) begin
                    w_write_done_d = 1'b0;
                    w_state_d      = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_write_done <= 1'b0;
            r_valid      <= '0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_addr       <= w_addr_d;
            r_wdata      <= w_wdata_d;
            r_rdata      <= w_rdata_d;
            r_write_done <= w_write_done_d;
            if (w_mem_we) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Array contents are not reset; a reset edge must still suppress a pending write.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign Mem_snoop_req  = (r_state == StReq);
    assign Mem_write_done = r_write_done;
    assign Data_in_Bus    = (r_state == StDrive) ? 1'b1 : 1'bz;
    assign Data_Bus_Com   = (r_state == StDrive) ? r_rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed vector table, corner-case sequences
// and randomized transactions scored against a transaction-level memory model.
module tb_main_memory_ctrl;

    localparam int unsigned RD_LAT = 4;
    localparam int unsigned WR_LAT = 2;
    localparam logic [31:0] FILL   = 32'h5A5A_5A5A;

    logic        clk;
    logic        rst_n;
    logic [31:0] Address_Com;
    wire  [31:0] Data_Bus_Com;
    logic        BusRd;
    logic        BusRdX;
    logic        Mem_wr;
    logic        Mem_oprn_abort;
    wire         Data_in_Bus;
    logic        Mem_write_done;
    logic        Mem_snoop_req;
    logic        Mem_snoop_gnt;

    logic [31:0] tb_bus_val;
    logic        tb_bus_en;
    assign Data_Bus_Com = tb_bus_en ? tb_bus_val : 32'bz;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index -> word for every entry written since the last reset.
    logic [31:0] mdl_mem [int unsigned];

    main_memory_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MEM_DEPTH_LOG2 (10),
        .RD_LATENCY     (RD_LAT),
        .WR_LATENCY     (WR_LAT),
        .FILL_PATTERN   (FILL)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Address_Com    (Address_Com),
        .Data_Bus_Com   (Data_Bus_Com),
        .BusRd          (BusRd),
        .BusRdX         (BusRdX),
        .Mem_wr         (Mem_wr),
        .Mem_oprn_abort (Mem_oprn_abort),
        .Data_in_Bus    (Data_in_Bus),
        .Mem_write_done (Mem_write_done),
        .Mem_snoop_req  (Mem_snoop_req),
        .Mem_snoop_gnt  (Mem_snoop_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] mdl_read(input logic [31:0] addr);
        int unsigned idx;
        idx = int'(addr[11:2]);
        if (mdl_mem.exists(idx)) return mdl_mem[idx];
        return addr ^ FILL;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_no_drive(input string name);
        chk(name, 32'(Data_in_Bus === 1'b1), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int hold);
        Address_Com = addr;
        tb_bus_val  = data;
        tb_bus_en   = 1'b1;
        Mem_wr      = 1'b1;
        tick();
        chk("wr_done_early", 32'(Mem_write_done), 32'd0);
        for (int i = 1; i < int'(WR_LAT); i++) begin
            tick();
            chk("wr_done_early", 32'(Mem_write_done), 32'd0);
        end
        tick();
        chk("wr_done_rise", 32'(Mem_write_done), 32'd1);
        chk("wr_no_req", 32'(Mem_snoop_req), 32'd0);
        mdl_mem[int'(addr[11:2])] = data;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("wr_done_hold", 32'(Mem_write_done), 32'd1);
        end
        Mem_wr    = 1'b0;
        tb_bus_en = 1'b0;
        tick();
        chk("wr_done_fall", 32'(Mem_write_done), 32'd0);
    endtask

    // abort_mode: 0 none, 1 abort in 2nd RD_WAIT cycle, 2 abort together with the grant.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp,
                           input int gnt_delay, input int abort_mode);
        Address_Com   = addr;
        BusRd         = 1'b1;
        Mem_snoop_gnt = (gnt_delay == 0 && abort_mode == 0);
        tick();
        Address_Com = $urandom;
        chk("rd_req_early", 32'(Mem_snoop_req), 32'd0);
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tick();
            chk("rd_req_early", 32'(Mem_snoop_req), 32'd0);
            chk_no_drive("rd_wait_no_drive");
            if (abort_mode == 1 && i == 1) Mem_oprn_abort = 1'b1;
        end
        if (abort_mode == 1) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("abort_no_req", 32'(Mem_snoop_req), 32'd0);
                chk_no_drive("abort_no_drive");
            end
            BusRd          = 1'b0;
            Mem_oprn_abort = 1'b0;
            tick();
            return;
        end
        tick();
        chk("rd_req_rise", 32'(Mem_snoop_req), 32'd1);
        chk_no_drive("rd_req_no_drive");
        for (int j = 0; j < gnt_delay; j++) begin
            tick();
            chk("rd_req_steady", 32'(Mem_snoop_req), 32'd1);
            chk_no_drive("rd_gnt_wait_no_drive");
        end
        Mem_snoop_gnt = 1'b1;
        if (abort_mode == 2) begin
            Mem_oprn_abort = 1'b1;
            tick();
            chk("abort_gnt_no_req", 32'(Mem_snoop_req), 32'd0);
            chk_no_drive("abort_gnt_no_drive");
            Mem_snoop_gnt  = 1'b0;
            Mem_oprn_abort = 1'b0;
            tick();
            chk_no_drive("abort_gnt_no_drive2");
            BusRd = 1'b0;
            tick();
            return;
        end
        tick();
        chk("rd_drive_flag", 32'(Data_in_Bus === 1'b1), 32'd1);
        chk("rd_data", Data_Bus_Com, exp);
        chk("rd_req_drop", 32'(Mem_snoop_req), 32'd0);
        Mem_snoop_gnt = 1'b0;
        BusRd         = 1'b0;
        tick();
        chk_no_drive("rd_after_drive");
        tick();
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h5A5A_5A4A};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0014, 32'h5A5A_5A4E};
        vecs[4] = '{1'b1, 32'h0000_1014, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 32'h0000_0014, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 32'h0000_0FFC, 32'h5A5A_55A6};
        vecs[7] = '{1'b1, 32'h0000_0FFC, 32'h0000_0001};
        vecs[8] = '{1'b0, 32'h0000_0FFC, 32'h0000_0001};

        rst_n = 1'b0; Address_Com = '0; BusRd = 1'b0; BusRdX = 1'b0; Mem_wr = 1'b0;
        Mem_oprn_abort = 1'b0; Mem_snoop_gnt = 1'b0; tb_bus_val = '0; tb_bus_en = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(Mem_snoop_req), 32'd0);
        chk("rst_done", 32'(Mem_write_done), 32'd0);
        chk_no_drive("rst_no_drive");
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].is_wr) do_write(vecs[v].addr, vecs[v].data, v % 3);
            else do_read(vecs[v].addr, vecs[v].data, 0, 0);
        end

        do_read(32'h0000_0010, 32'h0, 0, 1);
        do_read(32'h0000_0010, 32'hDEAD_BEEF, 5, 0);
        do_read(32'h0000_0010, 32'h0, 2, 2);

        // Write and read together: write wins; the read is not taken until all requests drop.
        Address_Com = 32'h20; tb_bus_val = 32'h1234_5678; tb_bus_en = 1'b1;
        Mem_wr = 1'b1; BusRd = 1'b1;
        for (int i = 0; i < int'(WR_LAT); i++) begin
            tick();
            chk("simul_done_early", 32'(Mem_write_done), 32'd0);
        end
        tick();
        chk("simul_done_rise", 32'(Mem_write_done), 32'd1);
        mdl_mem[int'(8)] = 32'h1234_5678;
        Mem_wr = 1'b0; tb_bus_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("simul_done_hold", 32'(Mem_write_done), 32'd1);
            chk("simul_no_req", 32'(Mem_snoop_req), 32'd0);
        end
        BusRd = 1'b0;
        tick();
        chk("simul_done_fall", 32'(Mem_write_done), 32'd0);
        do_read(32'h0000_0020, 32'h1234_5678, 0, 0);

        // Reset in the middle of a read after a completed write.
        do_write(32'h0000_0010, 32'h0BAD_F00D, 0);
        Address_Com = 32'h10; BusRd = 1'b1; Mem_snoop_gnt = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_rd_req", 32'(Mem_snoop_req), 32'd0);
            chk("rst_rd_done", 32'(Mem_write_done), 32'd0);
            chk_no_drive("rst_rd_no_drive");
        end
        rst_n = 1'b1; BusRd = 1'b0; Mem_snoop_gnt = 1'b0;
        mdl_mem.delete();
        tick();
        do_read(32'h0000_0010, 32'h5A5A_5A4A, 0, 0);

        // Reset one edge before the write would land: no array update.
        Address_Com = 32'h30; tb_bus_val = 32'hFFFF_0000; tb_bus_en = 1'b1; Mem_wr = 1'b1;
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_wr_done", 32'(Mem_write_done), 32'd0);
        end
        rst_n = 1'b1; Mem_wr = 1'b0; tb_bus_en = 1'b0;
        mdl_mem.delete();
        tick();
        do_read(32'h0000_0030, 32'h5A5A_5A6A, 1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_F03C;
            if ($urandom_range(0, 2) == 0) begin
                do_write(a, $urandom, int'($urandom_range(0, 2)));
            end else begin
                int am;
                am = int'($urandom_range(0, 5));
                do_read(a, mdl_read(a), int'($urandom_range(0, 3)),
                        (am == 4) ? 1 : ((am == 5) ? 2 : 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
